// File: rtl/mips_muldiv_unit_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit:
// operation and FSM state encodings plus a width helper.
package muldiv_defs;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((longint'(1) << r) < longint'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// One radix-2 iteration on the packed {upper, lower} working register:
// shift-add for multiply, restoring trial-subtract for divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  always_comb begin
    shifted = '0;
    diff    = '0;
    addend  = '0;
    sum     = '0;
    acc_o   = acc_i;
    if (is_div) begin
      // Upper half is the partial remainder, lower half shifts the dividend out / quotient in.
      shifted = acc_i[2*WIDTH-1:WIDTH-1];
      diff    = shifted - {1'b0, opnd_i};
      if (!diff[WIDTH]) begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_i[0]) addend = {1'b0, opnd_i};
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + addend;
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers;
// runs WIDTH/UNROLL iteration cycles plus one sign-fixup cycle per op.
module mips_muldiv_unit
  import muldiv_defs::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N  = WIDTH / UNROLL;
  localparam int unsigned CW = clog2(N + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               sign_quo_q, sign_quo_d;
  logic               sign_rem_q, sign_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    logic [2*WIDTH-1:0] acc_in;
    logic [2*WIDTH-1:0] acc_out;
    if (i == 0) begin : g_first
      assign acc_in = acc_q;
    end else begin : g_next
      assign acc_in = g_step[i-1].acc_out;
    end
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (op_q[1]),
      .acc_i  (acc_in),
      .opnd_i (opnd_q),
      .acc_o  (acc_out)
    );
  end
  assign step_res = g_step[UNROLL-1].acc_out;

  always_comb begin
    prod_fix = sign_quo_q ? -acc_q : acc_q;
    quo_fix  = sign_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (op_q[1]) begin
      res_lo = div0_q ? {WIDTH{1'b1}} : quo_fix;
      res_hi = div0_q ? a_raw_q : rem_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    div0_d     = div0_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    // MTHI/MTLO and flush both abort anything in flight and mask a same-cycle start.
    if (wr_hi || wr_lo || flush) begin
      state_d = S_IDLE;
      if (wr_hi) hi_d = wr_data;
      if (wr_lo) lo_d = wr_data;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_CALC;
            op_d       = op_e'(op);
            cnt_d      = CW'(N);
            a_raw_d    = src_a;
            sign_quo_d = signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            sign_rem_d = signed_op && src_a[WIDTH-1];
            div0_d     = op[1] && (src_b == '0);
            acc_d      = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opnd_d     = op[1] ? b_mag : a_mag;
          end
        end
        S_CALC: begin
          acc_d = step_res;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_MULT;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      div0_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      div0_q     <= div0_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q | (start & (state_q == S_IDLE));

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed + short random bench for mips_muldiv_unit at UNROLL=1 and UNROLL=4,
// with a queue of expected {hi,lo} results popped on completion.
module tb_mips_muldiv_unit;
  import muldiv_defs::*;

  logic        clk = 1'b0;
  logic        rst, start, start4, flush, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wr_data;
  logic        busy1, stall1, done1, busy4, stall4, done4;
  logic [31:0] hi1, lo1, hi4, lo4;

  int checks = 0;
  int fails  = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy1), .stall(stall1), .done(done1), .hi(hi1), .lo(lo1)
  );

  mips_muldiv_unit #(.WIDTH(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy4), .stall(stall4), .done(done4), .hi(hi4), .lo(lo4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Drive an op at a negedge; returns one negedge after the issuing edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit both);
    sb_q.push_back(model(o, a, b));
    op = o; src_a = a; src_b = b; start = 1'b1; start4 = both;
    #1;
    chk({tag, "/stall_on_issue"}, 64'(stall1), 64'd1);
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
  endtask

  task automatic finish(input string tag, input bit both, input int exp_n1);
    int n1, n4, d1, d4, guard;
    logic [63:0] exp;
    n1 = 0; n4 = 0; d1 = 0; d4 = 0; guard = 0;
    while ((busy1 || busy4) && guard < 200) begin
      if (busy1) n1++;
      if (busy4) n4++;
      if (done1) d1++;
      if (done4) d4++;
      guard++;
      @(negedge clk);
    end
    chk({tag, "/timeout"}, 64'(guard < 200), 64'd1);
    chk({tag, "/done_while_busy"}, 64'(d1), 64'd0);
    chk({tag, "/done"}, 64'(done1), 64'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    chk({tag, "/hilo"}, {hi1, lo1}, exp);
    chk({tag, "/busy_cycles"}, 64'(n1), 64'(exp_n1));
    if (both) begin
      chk({tag, "/u4_busy_cycles"}, 64'(n4), 64'd9);
      chk({tag, "/u4_done_pulses"}, 64'(d4), 64'd1);
      chk({tag, "/u4_hilo"}, {hi4, lo4}, exp);
    end
    @(negedge clk);
    chk({tag, "/done_single"}, 64'(done1), 64'd0);
  endtask

  task automatic no_done_window(input string tag);
    int d;
    d = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1) d++;
      @(negedge clk);
    end
    chk({tag, "/no_done"}, 64'(d), 64'd0);
  endtask

  initial begin
    logic [31:0] hp, lp;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b0; start = 1'b0; start4 = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset/hilo", {hi1, lo1}, 64'd0);
    chk("reset/busy_done_stall", {61'd0, busy1, done1, stall1}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b1);
    finish("multu_max", 1'b1, 33);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_m3x5", 1'b1);
    finish("mult_m3x5", 1'b1, 33);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7d2", 1'b1);
    finish("div_m7d2", 1'b1, 33);
    issue(OP_DIVU, 32'd10, 32'd0, "divu_by0", 1'b1);
    finish("divu_by0", 1'b1, 33);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);
    finish("div_ovf", 1'b1, 33);
    issue(OP_DIV, 32'hFFFF_FFF0, 32'd0, "div_neg_by0", 1'b1);
    finish("div_neg_by0", 1'b1, 33);

    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom);
      issue(ro, ra, rb, "rand", 1'b1);
      finish("rand", 1'b1, 33);
    end

    // Start while busy: ignored, first result intact.
    issue(OP_DIVU, 32'd100, 32'd7, "start_busy", 1'b0);
    repeat (5) @(negedge clk);
    op = OP_MULTU; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
    #1;
    chk("start_busy/stall", 64'(stall1), 64'd1);
    @(negedge clk);
    start = 1'b0;
    finish("start_busy", 1'b0, 27);

    // Flush mid-op: no result, no done.
    hp = hi1; lp = lo1;
    op = OP_MULTU; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush/busy", 64'(busy1), 64'd0);
    chk("flush/hilo", {hi1, lo1}, {hp, lp});
    no_done_window("flush");

    // MTLO while busy aborts the op and still writes LO.
    op = OP_MULT; src_a = 32'hFFFF_FFFD; src_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("wrlo_busy/busy", 64'(busy1), 64'd0);
    chk("wrlo_busy/hilo", {hi1, lo1}, {hp, 32'h1234});
    no_done_window("wrlo_busy");

    // MTHI+MTLO together with start in IDLE: writes win, start masked.
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE_F00D; start = 1'b1; op = OP_MULTU;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0; start = 1'b0;
    chk("wr_both/hilo", {hi1, lo1}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    chk("wr_both/busy", 64'(busy1), 64'd0);

    // Flush in IDLE masks a same-cycle start.
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_idle/busy", 64'(busy1), 64'd0);

    // Reset mid-op clears HI/LO and the in-flight op.
    op = OP_DIV; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_midop/hilo", {hi1, lo1}, 64'd0);
    chk("rst_midop/busy_done", {62'd0, busy1, done1}, 64'd0);
    no_done_window("rst_midop");

    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minmin", 1'b1);
    finish("mult_minmin", 1'b1, 33);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
